key_byte_loader: RTL and testbench

Upstream feeder for `key_generator`. It collects a user key as a stream of ASCII bytes, which is 1–16 bytes long. It pads the key to 128 bits with a fixed pad byte and presents the result on `original_key`. It then pulses `WE_key_generation` and waits for `generation_done`, with a timeout. Its outputs connect directly to the same-named inputs of `key_generator`.

---
 rtl/key_byte_loader.sv | 119 +++++++++++
 tb/tb_key_byte_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_byte_loader.sv
// Collects a 1-16 byte ASCII key, pads it to 128 bits with PAD_BYTE, then
// starts key_generator and waits (bounded) for its completion flag.
module key_byte_loader #(
   parameter logic [7:0] PAD_BYTE    = 8'h30,
   parameter int         GEN_TIMEOUT = 32
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   input  logic         key_last,
   output logic         byte_ready,
   output logic [127:0] original_key,
   output logic         WE_key_generation,
   input  logic         generation_done,
   output logic         key_ready,
   output logic         gen_error,
   output logic [4:0]   byte_count
);

   localparam int CNT_W = $clog2(GEN_TIMEOUT);

   typedef enum logic [1:0] {S_LOAD, S_PAD, S_START, S_WAIT} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [4:0]         r_byte_count;
   logic [127:0]       r_key;
   logic               r_key_ready;
   logic               r_gen_error;
   logic [CNT_W-1:0]   r_wait_cnt;

   logic               w_wr_en;
   logic [7:0]         w_wr_byte;
   logic               w_done_hit;
   logic               w_timeout_hit;
   logic               w_idx_last;
   logic               w_cnt_end;
   logic               w_first_byte;
   logic [6:0]         w_hi;

   assign w_idx_last   = (r_byte_count[3:0] == 4'd15);
   assign w_cnt_end    = (r_wait_cnt == CNT_W'(GEN_TIMEOUT - 1));
   assign w_first_byte = (r_state == S_LOAD) && byte_valid && (r_byte_count == 5'd0);
   // Byte index k lives at bits [127-8k -: 8]
   assign w_hi         = 7'd127 - {r_byte_count[3:0], 3'b000};

   always_ff @(posedge clk) begin
      if (!n_rst) r_state <= S_LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_wr_en       = 1'b0;
      w_wr_byte     = byte_data;
      w_done_hit    = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (byte_valid) begin
               w_wr_en = 1'b1;
               if (key_last || w_idx_last) w_next = w_idx_last ? S_START : S_PAD;
            end
         end
         S_PAD: begin
            w_wr_en   = 1'b1;
            w_wr_byte = PAD_BYTE;
            if (w_idx_last) w_next = S_START;
         end
         S_START: w_next = S_WAIT;
         S_WAIT: begin
            // Completion takes priority over a coincident timeout
            if (generation_done) begin
               w_done_hit = 1'b1;
               w_next     = S_LOAD;
            end else if (w_cnt_end) begin
               w_timeout_hit = 1'b1;
               w_next        = S_LOAD;
            end
         end
         default: w_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_byte_count <= 5'd0;
         r_key        <= 128'd0;
         r_key_ready  <= 1'b0;
         r_gen_error  <= 1'b0;
         r_wait_cnt   <= '0;
      end else begin
         if (w_wr_en) begin
            r_key[w_hi -: 8] <= w_wr_byte;
            r_byte_count     <= r_byte_count + 5'd1;
         end
         if (w_first_byte) begin
            r_key_ready <= 1'b0;
            r_gen_error <= 1'b0;
         end
         if (r_state == S_START) begin
            r_byte_count <= 5'd0;
            r_wait_cnt   <= '0;
         end
         if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         if (w_done_hit)    r_key_ready <= 1'b1;
         if (w_timeout_hit) r_gen_error <= 1'b1;
      end
   end

   assign byte_ready        = (r_state == S_LOAD);
   assign WE_key_generation = (r_state == S_START);
   assign original_key      = r_key;
   assign key_ready         = r_key_ready;
   assign gen_error         = r_gen_error;
   assign byte_count        = r_byte_count;

endmodule

// File: tb/tb_key_byte_loader.sv
// Self-checking bench for key_byte_loader: directed scenarios plus randomized
// keys compared against a padded-key / latency reference model.
module tb_key_byte_loader;

   logic         clk;
   logic         n_rst;
   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         key_last;
   logic         byte_ready;
   logic [127:0] original_key;
   logic         WE_key_generation;
   logic         generation_done;
   logic         key_ready;
   logic         gen_error;
   logic [4:0]   byte_count;

   int checks = 0;
   int errors = 0;

   key_byte_loader #(.PAD_BYTE(8'h30), .GEN_TIMEOUT(32)) dut (
      .clk(clk), .n_rst(n_rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .key_last(key_last), .byte_ready(byte_ready), .original_key(original_key),
      .WE_key_generation(WE_key_generation), .generation_done(generation_done),
      .key_ready(key_ready), .gen_error(gen_error), .byte_count(byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: first n bytes in order, every remaining position holds '0'
   function automatic logic [127:0] exp_key(input logic [7:0] kb[16], input int n);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = (k < n) ? kb[k] : 8'h30;
      return r;
   endfunction

   // Feeds one key, then plays the key_generator responder: done is raised
   // d cycles after the cycle in which the start pulse is seen (d<0: never).
   task automatic run_key(input logic [7:0] kb[16], input int n, input bit use_last,
                          input int d, input bit hold, input bit noise,
                          output logic [127:0] key_we, output int we_lat, output int we_cnt,
                          output int pad_cyc, output int wait_len, output bit br_bad,
                          output bit tmo_bad, output logic kr_first, output logic err_first,
                          output logic kr_end, output logic err_end, output logic [4:0] bc_end);
      int lat;
      int end_lat;
      key_we = '0; we_lat = -1; we_cnt = 0; pad_cyc = 0; br_bad = 0; tmo_bad = 0;
      kr_first = 1'bx; err_first = 1'bx; end_lat = 0;
      for (int i = 0; i < n; i++) begin
         byte_valid      = 1'b1;
         byte_data       = kb[i];
         key_last        = use_last && (i == n - 1);
         generation_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (i == 0) begin
            kr_first  = key_ready;
            err_first = gen_error;
         end
      end
      byte_valid = hold;
      byte_data  = 8'hEE;
      key_last   = 1'b0;
      lat = 1;
      forever begin
         if (WE_key_generation) begin
            if (we_lat < 0) we_lat = lat;
            we_cnt++;
            key_we = original_key;
         end else if (we_lat < 0) begin
            if (byte_ready) br_bad = 1;
            else pad_cyc++;
         end
         if (we_lat >= 0 && lat > we_lat && byte_ready) begin
            end_lat = lat;
            break;
         end
         if (lat >= 200) begin
            tmo_bad = 1;
            break;
         end
         generation_done = (we_lat < 0) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0)
                                        : 1'(lat - we_lat == d);
         lat++;
         @(negedge clk);
      end
      byte_valid      = 1'b0;
      generation_done = 1'b0;
      kr_end   = key_ready;
      err_end  = gen_error;
      bc_end   = byte_count;
      wait_len = end_lat - we_lat - 1;
   endtask

   task automatic test_reset;
      n_rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; key_last = 1'b0; generation_done = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (original_key !== 128'd0) begin errors++; $display("FAIL reset_key got %h want 0", original_key); end
      checks++; if ({byte_count, WE_key_generation, key_ready, gen_error} !== 8'd0) begin errors++; $display("FAIL reset_ctrl got cnt=%0d we=%b kr=%b err=%b want all 0", byte_count, WE_key_generation, key_ready, gen_error); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", byte_ready); end
      n_rst = 1'b1;
   endtask

   task automatic test_padded_key;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      logic [8*12-1:0] s;
      s = 96'h7468697369737468656b6579;
      for (int i = 0; i < 16; i++) kb[i] = (i < 12) ? s[95 - 8*i -: 8] : 8'h00;
      run_key(kb, 12, 1, 10, 0, 0, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (kw !== 128'h7468697369737468656b657930303030) begin errors++; $display("FAIL pad12_key got %h want 7468697369737468656b657930303030", kw); end
      // start pulse in the cycle after edge E+4 (first sample after E is lat 1)
      checks++; if (wl !== 5 || wc !== 1) begin errors++; $display("FAIL pad12_we got lat=%0d cnt=%0d want lat=5 cnt=1", wl, wc); end
      checks++; if (pc !== 4 || bb) begin errors++; $display("FAIL pad12_pad got %0d ready_bad=%b want 4 0", pc, bb); end
      checks++; if (ke !== 1'b1 || ee !== 1'b0 || wlen !== 10 || tb) begin errors++; $display("FAIL pad12_done got kr=%b err=%b wait=%0d want 1 0 10", ke, ee, wlen); end
      checks++; if (original_key !== kw || bc !== 5'd0) begin errors++; $display("FAIL pad12_hold got %h cnt=%0d want %h cnt=0", original_key, bc, kw); end
   endtask

   task automatic test_full_key;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      for (int i = 0; i < 16; i++) kb[i] = 8'h41 + 8'(i);
      run_key(kb, 16, 0, 3, 0, 1, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (kw !== 128'h4142434445464748494a4b4c4d4e4f50) begin errors++; $display("FAIL full_key got %h want 4142434445464748494a4b4c4d4e4f50", kw); end
      checks++; if (wl !== 1 || wc !== 1 || pc !== 0) begin errors++; $display("FAIL full_we got lat=%0d cnt=%0d pad=%0d want 1 1 0", wl, wc, pc); end
      checks++; if (kf !== 1'b0) begin errors++; $display("FAIL full_clear_kr got %b want 0", kf); end
      checks++; if (ke !== 1'b1 || ee !== 1'b0 || wlen !== 3) begin errors++; $display("FAIL full_done got kr=%b err=%b wait=%0d want 1 0 3", ke, ee, wlen); end
   endtask

   task automatic test_one_byte_hold;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      for (int i = 0; i < 16; i++) kb[i] = 8'h00;
      kb[0] = 8'h7a;
      run_key(kb, 1, 1, 5, 1, 1, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (kw !== 128'h7a303030303030303030303030303030) begin errors++; $display("FAIL one_key got %h want 7a303030303030303030303030303030", kw); end
      checks++; if (pc !== 15 || bb || wl !== 16 || wc !== 1) begin errors++; $display("FAIL one_pad got pad=%0d ready_bad=%b lat=%0d cnt=%0d want 15 0 16 1", pc, bb, wl, wc); end
      checks++; if (bc !== 5'd0 || original_key !== kw || wlen !== 5) begin errors++; $display("FAIL one_held_byte got cnt=%0d key=%h wait=%0d want 0 %h 5", bc, original_key, wlen, kw); end
   endtask

   task automatic test_timeout;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      for (int i = 0; i < 16; i++) kb[i] = 8'($urandom);
      run_key(kb, 5, 1, -1, 0, 0, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (ee !== 1'b1 || ke !== 1'b0) begin errors++; $display("FAIL tmo_flags got kr=%b err=%b want 0 1", ke, ee); end
      checks++; if (wlen !== 32 || tb) begin errors++; $display("FAIL tmo_len got %0d want 32", wlen); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready got %b want 1", byte_ready); end
      run_key(kb, 2, 1, 4, 0, 0, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (ef !== 1'b0) begin errors++; $display("FAIL tmo_clear got err=%b want 0", ef); end
      checks++; if (kw !== exp_key(kb, 2) || ke !== 1'b1) begin errors++; $display("FAIL tmo_next got %h kr=%b want %h 1", kw, ke, exp_key(kb, 2)); end
   endtask

   task automatic test_done_last_cycle;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      for (int i = 0; i < 16; i++) kb[i] = 8'($urandom);
      run_key(kb, 7, 1, 32, 0, 0, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (ke !== 1'b1 || ee !== 1'b0 || wlen !== 32) begin errors++; $display("FAIL edge_done got kr=%b err=%b wait=%0d want 1 0 32", ke, ee, wlen); end
   endtask

   task automatic test_reset_mid_pad;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1; byte_data = 8'h61 + 8'(i); key_last = (i == 2);
         @(negedge clk);
      end
      byte_valid = 1'b0; key_last = 1'b0;
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      checks++; if (original_key !== 128'd0 || byte_count !== 5'd0) begin errors++; $display("FAIL rst_mid_data got %h cnt=%0d want 0 0", original_key, byte_count); end
      checks++; if ({WE_key_generation, key_ready, gen_error, byte_ready} !== 4'b0001) begin errors++; $display("FAIL rst_mid_ctrl got we=%b kr=%b err=%b rdy=%b want 0 0 0 1", WE_key_generation, key_ready, gen_error, byte_ready); end
      for (int i = 0; i < 16; i++) kb[i] = 8'($urandom_range(32, 126));
      run_key(kb, 12, 1, 6, 0, 0, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
      checks++; if (kw !== exp_key(kb, 12) || wl !== 5 || ke !== 1'b1) begin errors++; $display("FAIL rst_mid_reload got %h lat=%0d kr=%b want %h 5 1", kw, wl, ke, exp_key(kb, 12)); end
   endtask

   task automatic test_random;
      logic [7:0] kb[16];
      logic [127:0] kw; int wl, wc, pc, wlen; bit bb, tb; logic kf, ef, ke, ee; logic [4:0] bc;
      int n, d, exp_wait; bit ul; logic exp_kr;
      for (int t = 0; t < 10; t++) begin
         n  = $urandom_range(1, 16);
         ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         d  = $urandom_range(1, 40);
         for (int i = 0; i < 16; i++) kb[i] = 8'($urandom);
         run_key(kb, n, ul, d, 1'($urandom_range(0, 1)), 1, kw, wl, wc, pc, wlen, bb, tb, kf, ef, ke, ee, bc);
         exp_kr   = (d <= 32);
         exp_wait = (d <= 32) ? d : 32;
         checks++; if (kw !== exp_key(kb, n)) begin errors++; $display("FAIL rnd%0d_key n=%0d got %h want %h", t, n, kw, exp_key(kb, n)); end
         checks++; if (wl !== 17 - n || wc !== 1 || pc !== 16 - n || bb || tb) begin errors++; $display("FAIL rnd%0d_timing n=%0d got lat=%0d cnt=%0d pad=%0d want %0d 1 %0d", t, n, wl, wc, pc, 17 - n, 16 - n); end
         checks++; if (ke !== exp_kr || ee !== !exp_kr || wlen !== exp_wait) begin errors++; $display("FAIL rnd%0d_result d=%0d got kr=%b err=%b wait=%0d want %b %b %0d", t, d, ke, ee, wlen, exp_kr, !exp_kr, exp_wait); end
      end
   endtask

   initial begin
      test_reset();
      test_padded_key();
      test_full_key();
      test_one_byte_hold();
      test_timeout();
      test_done_last_cycle();
      test_reset_mid_pad();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
